serial_paralelo: RTL and testbench
==================================

Name: serial_paralelo

Overview:
Receive-side deserializer for the 1-bit lane produced by the transmit paralelo_serial stage. It consumes the serial stream MSB-first on clk_32f and locks byte alignment on the idle/comma character COM (8'hBC), which the transmitter sends while its valid_in is low. After COM_NEEDED consecutive aligned COM bytes, it declares the link active. From then on it emits each non-COM byte as 8-bit parallel data with a valid flag, for the downstream phy_rx byte path.

Parameters:
WIDTH, 8, parallel word width; the bit counter is log2(WIDTH) bits.
COM, 8'hBC, comma/idle character used for alignment and as the "no data" marker.
COM_NEEDED, 4, consecutive aligned COM bytes required to assert active.

Ports:
clk_32f  input  1  bit-rate clock; one serial bit per rising edge.
reset_L  input  1  synchronous, active-low reset.
data_in  input  1  serial bit from the paralelo_serial stage, MSB of each byte first.
data_out  output  WIDTH  last received data byte, registered.
valid_out  output  1  high while data_out holds a data (non-COM) byte received in ACTIVE.
active  output  1  link aligned and locked; high in ACTIVE.

Behaviour:
- Single clock, clk_32f. Reset is synchronous and active-low: on a rising edge with reset_L=0 (including mid-byte or mid-operation), the block applies:
  - state=SEARCH, shreg=0, bit_cnt=0, com_cnt=0;
  - data_out=0, valid_out=0, active=0, all visible the same edge.
- Shift register, every cycle: shreg <= {shreg[WIDTH-2:0], data_in}. Call word = {shreg[WIDTH-2:0], data_in}, the byte completed by the current bit.
- bit_cnt increments every cycle and wraps WIDTH-1 -> 0. A boundary is any cycle with bit_cnt==WIDTH-1 in ALIGN or ACTIVE.
- SEARCH:
  - bit_cnt is ignored; word is checked every cycle (sliding-window search).
  - On word==COM: bit_cnt<=0, com_cnt<=1, go to ALIGN. If COM_NEEDED==1, go directly to ACTIVE.
  - Otherwise stay in SEARCH.
- ALIGN (checked only at a boundary):
  - word==COM: com_cnt+1. When the count reaches COM_NEEDED, go to ACTIVE with active<=1 the same edge.
  - word!=COM: com_cnt<=0, go to SEARCH.
  - Outputs stay at reset values throughout ALIGN.
- ACTIVE (checked only at a boundary):
  - word!=COM: data_out<=word, valid_out<=1.
  - word==COM: valid_out<=0 and data_out holds its previous value.
  - Outputs hold for the full 8 cycles between boundaries, i.e. data is presented at 4f byte rate.
  - ACTIVE is left only by reset; there is no loss-of-lock detection.
- Latency: a byte's last (LSB) bit is sampled on edge N; data_out/valid_out change on that same edge N and are visible from then until edge N+8.
- com_cnt saturates at COM_NEEDED; it is not used after ACTIVE.
- data_in is 2-state; X on data_in is a bench error.

Test Plan:
1. Hold reset_L=0 for 3 cycles while data_in toggles -> data_out=8'h00, valid_out=0, active=0 throughout. Then release.
2. Send 3 random bits, then 4x 8'hBC MSB-first -> active rises on the edge sampling the LSB of the 4th BC. valid_out stays 0 for all of this.
3. Continue from (2) with 8'hCC, 8'hAA, 8'hBC, 8'hFF, 8'hEE:
   - data_out=CC with valid_out=1, then AA.
   - On the BC byte, valid_out=0 and data_out stays AA.
   - Then FF, then EE, each held 8 cycles.
4. Send 2x BC, 8'h12, then 4x BC -> the 8'h12 returns the block to SEARCH. active asserts only after the 4 later BCs; 8'h12 never appears on data_out.
5. Assert reset_L=0 mid-byte in ACTIVE -> next edge: active=0, valid_out=0, data_out=0. Re-lock requires 4 fresh BCs.
6. Back-to-back data with no COM after lock (8'h01..8'h08) -> eight consecutive 8-cycle windows with valid_out=1 and correct bytes. Output compared against a bit-accurate model.

Source files
------------

// File: rtl/serial_paralelo.sv
// Receive deserializer: aligns a MSB-first serial lane on the COM character,
// locks after COM_NEEDED aligned commas, then presents data bytes at byte rate.
module serial_paralelo #(
    parameter int unsigned      WIDTH      = 8,
    parameter logic [WIDTH-1:0] COM        = 8'hBC,
    parameter int unsigned      COM_NEEDED = 4
) (
    input  logic             clk_32f,
    input  logic             reset_L,
    input  logic             data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             valid_out,
    output logic             active
);

    localparam int unsigned     CntW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned     ComW      = $clog2(COM_NEEDED + 1);
    localparam logic [CntW-1:0] LastBit   = CntW'(WIDTH - 1);
    localparam logic [ComW-1:0] ComTarget = ComW'(COM_NEEDED);

    typedef enum logic [1:0] {StSearch, StAlign, StActive} state_e;

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] word;
    logic [CntW-1:0]  bit_cnt;
    logic [ComW-1:0]  com_cnt;
    logic             boundary;
    logic             is_com;

    // word is the byte completed by the bit arriving this cycle
    assign word     = {shreg[WIDTH-2:0], data_in};
    assign is_com   = (word == COM);
    assign boundary = (bit_cnt == LastBit);

    always_ff @(posedge clk_32f) begin
        if (!reset_L) begin
            state     <= StSearch;
            shreg     <= '0;
            bit_cnt   <= '0;
            com_cnt   <= '0;
            data_out  <= '0;
            valid_out <= 1'b0;
            active    <= 1'b0;
        end else begin
            shreg   <= word;
            bit_cnt <= boundary ? '0 : bit_cnt + 1'b1;
            unique case (state)
                StSearch: begin
                    // Sliding-window search; a hit re-phases the bit counter
                    if (is_com) begin
                        bit_cnt <= '0;
                        com_cnt <= ComW'(1);
                        if (COM_NEEDED <= 1) begin
                            state  <= StActive;
                            active <= 1'b1;
                        end else begin
                            state <= StAlign;
                        end
                    end
                end
                StAlign: begin
                    if (boundary) begin
                        if (is_com) begin
                            if (com_cnt + 1'b1 >= ComTarget) begin
                                com_cnt <= ComTarget;
                                state   <= StActive;
                                active  <= 1'b1;
                            end else begin
                                com_cnt <= com_cnt + 1'b1;
                            end
                        end else begin
                            com_cnt <= '0;
                            state   <= StSearch;
                        end
                    end
                end
                StActive: begin
                    if (boundary) begin
                        if (!is_com) begin
                            data_out  <= word;
                            valid_out <= 1'b1;
                        end else begin
                            valid_out <= 1'b0;
                        end
                    end
                end
                default: state <= StSearch;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_paralelo.sv
// Directed bench for serial_paralelo: alignment, lock, data path, COM gaps and reset.
module tb_serial_paralelo;

    localparam logic [7:0] Com = 8'hBC;

    logic       clk_32f;
    logic       reset_L;
    logic       data_in;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;

    int checks = 0;
    int errors = 0;

    // Expected output state, updated once per completed byte
    logic       m_act;
    logic       m_val;
    logic [7:0] m_dout;

    serial_paralelo #(
        .WIDTH      (8),
        .COM        (8'hBC),
        .COM_NEEDED (4)
    ) dut (
        .clk_32f   (clk_32f),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .data_out  (data_out),
        .valid_out (valid_out),
        .active    (active)
    );

    initial clk_32f = 1'b0;
    always #5 clk_32f = ~clk_32f;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".active"}, {7'd0, active}, {7'd0, m_act});
        check({tag, ".valid_out"}, {7'd0, valid_out}, {7'd0, m_val});
        check({tag, ".data_out"}, data_out, m_dout);
    endtask

    // One bit, outputs expected to be unchanged
    task automatic send_bit(input logic b, input string tag);
        @(negedge clk_32f);
        data_in = b;
        @(posedge clk_32f);
        #1;
        check_outputs(tag);
    endtask

    // Full byte MSB-first: previous outputs must hold for the first 7 bits and
    // update on the LSB edge. post_act is the hand-derived lock state after the byte.
    task automatic send_byte(input logic [7:0] b, input logic post_act, input string tag);
        logic       pv;
        logic [7:0] pd;
        pv = m_act && (b != Com);
        pd = pv ? b : m_dout;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk_32f);
            data_in = b[i];
            @(posedge clk_32f);
            #1;
            if (i == 0) begin
                m_act  = post_act;
                m_val  = pv;
                m_dout = pd;
                check_outputs($sformatf("%s.lsb", tag));
            end else begin
                check_outputs($sformatf("%s.hold%0d", tag, i));
            end
        end
    endtask

    task automatic clear_model();
        m_act  = 1'b0;
        m_val  = 1'b0;
        m_dout = 8'h00;
    endtask

    initial begin
        logic [2:0] rb;
        clear_model();
        reset_L = 1'b0;
        data_in = 1'b0;

        // 1: reset held with toggling input
        for (int i = 0; i < 3; i++) send_bit(i[0] ^ 1'b1, $sformatf("reset%0d", i));
        reset_L = 1'b1;

        // 2: random preamble, then four commas lock the link
        rb = 3'($urandom_range(0, 7));
        for (int i = 2; i >= 0; i--) send_bit(rb[i], "preamble");
        send_byte(Com, 1'b0, "com1");
        send_byte(Com, 1'b0, "com2");
        send_byte(Com, 1'b0, "com3");
        send_byte(Com, 1'b1, "com4");

        // 3: data with a COM gap
        send_byte(8'hCC, 1'b1, "d_cc");
        send_byte(8'hAA, 1'b1, "d_aa");
        send_byte(Com,   1'b1, "gap_bc");
        send_byte(8'hFF, 1'b1, "d_ff");
        send_byte(8'hEE, 1'b1, "d_ee");

        // 5: reset three bits into the next byte
        send_bit(1'b0, "mid0");
        send_bit(1'b1, "mid1");
        send_bit(1'b0, "mid2");
        @(negedge clk_32f);
        reset_L = 1'b0;
        data_in = 1'b1;
        @(posedge clk_32f);
        #1;
        clear_model();
        check_outputs("midreset");
        send_bit(1'b1, "midreset_hold");
        reset_L = 1'b1;

        // 4: broken alignment sends the block back to search
        send_byte(Com,   1'b0, "rc1");
        send_byte(Com,   1'b0, "rc2");
        send_byte(8'h12, 1'b0, "bad12");
        send_byte(Com,   1'b0, "rl1");
        send_byte(Com,   1'b0, "rl2");
        send_byte(Com,   1'b0, "rl3");
        send_byte(Com,   1'b1, "rl4");

        // 6: back-to-back data, then a comma to close the last window
        for (int k = 1; k <= 8; k++) send_byte(8'(k), 1'b1, $sformatf("b2b%0d", k));
        send_byte(Com, 1'b1, "tail_bc");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
